rv32_decode_exec_unit: RTL and testbench
========================================

Name: rv32_decode_exec_unit

Overview:
- Combined instruction-decode, control-generation and ALU stage for the 5-stage RV32I core.
- Takes the fetched instruction, its PC and the two register-file read operands. Produces register indices, control enables, the ALU result and the branch redirect.
- All outputs are registered, with one cycle of latency.
- Downstream, the memory stage uses wr_en/lw_en/sw_en/alu_out and the PC unit uses br_taken/br_target.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  instr/pc/data1/data2 are valid this cycle
- instr  in  32  instruction word
- pc  in  32  address of instr
- data1  in  32  rs1 operand value
- data2  in  32  rs2 operand value
- rs1  out  5  instr[19:15], combinational (drives register-file read)
- rs2  out  5  instr[24:20], combinational
- out_valid  out  1  registered in_valid
- rd  out  5  registered destination register
- wr_en  out  1  register write-back enable
- lw_en  out  1  load word
- sw_en  out  1  store word
- store_data  out  32  registered data2, used for sw
- alu_out  out  32  ALU result, or effective address for lw/sw
- br_taken  out  1  branch taken
- br_target  out  32  pc + sext(B-imm)
- illegal  out  1  unsupported opcode/funct combination

Behaviour:
- Field decode:
  - op = instr[6:0], rd = [11:7], funct3 = [14:12], funct7 = [31:25].
  - I-imm = sext(instr[31:20]).
  - S-imm = sext({[31:25],[11:7]}).
  - B-imm = sext({[31],[7],[30:25],[11:8],1'b0}).
- Supported opcodes:
  - 0110011 R-type: add, sub, sll, slt, sltu, xor, srl, sra, or, and.
  - 0010011 I-ALU: addi, slti, sltiu, xori, ori, andi, slli, srli, srai.
  - 0000011 lw (funct3 = 010).
  - 0100011 sw (funct3 = 010).
  - 1100011 branches: beq, bne, blt, bge, bltu, bgeu.
- Operand B is data2 for R-type and branch, and the sign-extended immediate otherwise.
- sub is selected only for R-type, funct3 = 000, funct7 = 0100000.
- sra/srai are selected by funct7[5] = 1 with funct3 = 101. Any other funct7 with R-type is illegal, except 0000000 and this one.
- Shift amount is operand B[4:0].
- slt/blt/bge compare signed; sltu/bltu/bgeu compare unsigned. slt/sltu results are 0 or 1.
- lw/sw: alu_out = data1 + I-imm (lw) or data1 + S-imm (sw), wrapping mod 2^32.
- Branch: alu_out = 0, wr_en = 0. br_target = pc + B-imm (mod 2^32); br_taken = condition result.
- Control:
  - wr_en = 1 for R, I-ALU, lw.
  - lw_en = 1 only for lw; sw_en = 1 only for sw.
  - rd is forced to 0 when wr_en = 0.
  - Writes with rd = x0 keep wr_en = 1; the register file ignores them.
- Illegal or unsupported instruction (including lw/sw with funct3 ≠ 010): illegal = 1. All enables, br_taken and alu_out are 0.
- Timing: every registered output is sampled on the rising clk edge from the inputs present in that cycle. Latency is exactly 1 cycle; throughput is 1 instruction per cycle.
- in_valid = 0 in a cycle: next-cycle outputs have out_valid = 0 and all enables, br_taken and illegal = 0. Data outputs may hold any value but are driven to 0.
- Reset: when rst = 1 at a clock edge, all registered outputs go to 0, overriding in_valid. This includes mid-stream; the instruction in flight is discarded.
- rs1/rs2 are combinational and unaffected by rst.

Test Plan:
- rst = 1 for 2 cycles with in_valid = 1 and instr = add: every registered output is 0. After release, the first instruction appears 1 cycle later.
- add x3,x1,x2 (0x002081B3), data1 = 7, data2 = 5 → next cycle: alu_out = 12, rd = 3, wr_en = 1. Then sub (0x402081B3) → alu_out = 2. With data1 = 0, data2 = 1, sub → 0xFFFFFFFF.
- Shifts and compares with data1 = 0x80000000, data2 = 4:
  - sra → 0xF8000000; srl → 0x08000000.
  - slt → 1; sltu → 0.
  - srai with shamt 31 → 0xFFFFFFFF.
- lw x5,-4(x1) (0xFFC0A283), data1 = 0x100 → alu_out = 0xFC, lw_en = 1, wr_en = 1, rd = 5.
- sw x2,8(x1) (0x0020A423), data1 = 0x100, data2 = 0xDEAD → alu_out = 0x108, sw_en = 1, store_data = 0xDEAD, wr_en = 0.
- beq x1,x2,-8 (0xFE208CE3), pc = 0x40:
  - data1 = data2 = 3 → br_taken = 1, br_target = 0x38.
  - data1 = 3, data2 = 4 → br_taken = 0.
- Illegal opcode 0x0000007F → illegal = 1 and all enables 0.
- Back-to-back stream of 4 mixed instructions checks one result per cycle.

Source files
------------

// File: rtl/rv32_decode_exec_unit.sv
// Decode, control generation and ALU stage of the 5-stage RV32I core.
// Register indices leave combinationally; every other output is registered with one cycle of latency.
module rv32_decode_exec_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] data1,
    input  logic [XLEN-1:0] data2,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic            out_valid,
    output logic [4:0]      rd,
    output logic            wr_en,
    output logic            lw_en,
    output logic            sw_en,
    output logic [XLEN-1:0] store_data,
    output logic [XLEN-1:0] alu_out,
    output logic            br_taken,
    output logic [XLEN-1:0] br_target,
    output logic            illegal
);

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] F7_STD = 7'b0000000;
    localparam logic [6:0] F7_ALT = 7'b0100000;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rd_field;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;

    assign rs1      = instr[19:15];
    assign rs2      = instr[24:20];
    assign opcode   = instr[6:0];
    assign rd_field = instr[11:7];
    assign funct3   = instr[14:12];
    assign funct7   = instr[31:25];
    assign imm_i    = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign imm_s    = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b    = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};

    logic            is_r, is_i, is_ld, is_st, is_br;
    logic            legal;
    logic            alt_op;
    logic [XLEN-1:0] op_b;
    logic [4:0]      shamt;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] mem_addr;
    logic            lt_s, lt_u, eq;
    logic            br_cond;

    // Opcode classification and legality; funct7 only qualifies R-type and immediate shifts.
    always_comb begin
        is_r  = (opcode == OP_R);
        is_i  = (opcode == OP_I);
        is_ld = (opcode == OP_LD);
        is_st = (opcode == OP_ST);
        is_br = (opcode == OP_BR);
        legal = 1'b0;
        if (is_r) begin
            legal = (funct7 == F7_STD) ||
                    ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        end else if (is_i) begin
            if (funct3 == 3'b001)
                legal = (funct7 == F7_STD);
            else if (funct3 == 3'b101)
                legal = (funct7 == F7_STD) || (funct7 == F7_ALT);
            else
                legal = 1'b1;
        end else if (is_ld || is_st) begin
            legal = (funct3 == 3'b010);
        end else if (is_br) begin
            legal = (funct3 != 3'b010) && (funct3 != 3'b011);
        end
    end

    // Subtract only exists for R-type; arithmetic right shift for both R and I forms.
    assign alt_op   = funct7[5] && (((funct3 == 3'b000) && is_r) || (funct3 == 3'b101));
    assign op_b     = (is_r || is_br) ? data2 : (is_st ? imm_s : imm_i);
    assign shamt    = op_b[4:0];
    assign mem_addr = data1 + op_b;
    assign lt_s     = ($signed(data1) < $signed(op_b));
    assign lt_u     = (data1 < op_b);
    assign eq       = (data1 == op_b);

    always_comb begin
        alu_res = '0;
        case (funct3)
            3'b000:  alu_res = alt_op ? (data1 - op_b) : (data1 + op_b);
            3'b001:  alu_res = data1 << shamt;
            3'b010:  alu_res = {{(XLEN-1){1'b0}}, lt_s};
            3'b011:  alu_res = {{(XLEN-1){1'b0}}, lt_u};
            3'b100:  alu_res = data1 ^ op_b;
            3'b101:  alu_res = alt_op ? XLEN'($signed(data1) >>> shamt) : (data1 >> shamt);
            3'b110:  alu_res = data1 | op_b;
            default: alu_res = data1 & op_b;
        endcase
    end

    always_comb begin
        br_cond = 1'b0;
        case (funct3)
            3'b000:  br_cond = eq;
            3'b001:  br_cond = !eq;
            3'b100:  br_cond = lt_s;
            3'b101:  br_cond = !lt_s;
            3'b110:  br_cond = lt_u;
            3'b111:  br_cond = !lt_u;
            default: br_cond = 1'b0;
        endcase
    end

    logic            out_valid_d, out_valid_q;
    logic [4:0]      rd_d, rd_q;
    logic            wr_en_d, wr_en_q;
    logic            lw_en_d, lw_en_q;
    logic            sw_en_d, sw_en_q;
    logic [XLEN-1:0] store_data_d, store_data_q;
    logic [XLEN-1:0] alu_out_d, alu_out_q;
    logic            br_taken_d, br_taken_q;
    logic [XLEN-1:0] br_target_d, br_target_q;
    logic            illegal_d, illegal_q;

    // Idle and illegal slots leave every enable low so nothing downstream acts on them.
    always_comb begin
        out_valid_d  = in_valid;
        rd_d         = '0;
        wr_en_d      = 1'b0;
        lw_en_d      = 1'b0;
        sw_en_d      = 1'b0;
        store_data_d = '0;
        alu_out_d    = '0;
        br_taken_d   = 1'b0;
        br_target_d  = '0;
        illegal_d    = 1'b0;
        if (in_valid) begin
            store_data_d = data2;
            br_target_d  = pc + imm_b;
            if (!legal) begin
                illegal_d = 1'b1;
            end else begin
                wr_en_d    = is_r || is_i || is_ld;
                lw_en_d    = is_ld;
                sw_en_d    = is_st;
                br_taken_d = is_br && br_cond;
                rd_d       = (is_r || is_i || is_ld) ? rd_field : 5'd0;
                if (is_ld || is_st)
                    alu_out_d = mem_addr;
                else if (!is_br)
                    alu_out_d = alu_res;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            rd_q         <= '0;
            wr_en_q      <= 1'b0;
            lw_en_q      <= 1'b0;
            sw_en_q      <= 1'b0;
            store_data_q <= '0;
            alu_out_q    <= '0;
            br_taken_q   <= 1'b0;
            br_target_q  <= '0;
            illegal_q    <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            rd_q         <= rd_d;
            wr_en_q      <= wr_en_d;
            lw_en_q      <= lw_en_d;
            sw_en_q      <= sw_en_d;
            store_data_q <= store_data_d;
            alu_out_q    <= alu_out_d;
            br_taken_q   <= br_taken_d;
            br_target_q  <= br_target_d;
            illegal_q    <= illegal_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign rd         = rd_q;
    assign wr_en      = wr_en_q;
    assign lw_en      = lw_en_q;
    assign sw_en      = sw_en_q;
    assign store_data = store_data_q;
    assign alu_out    = alu_out_q;
    assign br_taken   = br_taken_q;
    assign br_target  = br_target_q;
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_rv32_decode_exec_unit.sv
// Directed bench for rv32_decode_exec_unit: an instruction-level reference model
// is compared every cycle, and literal expectations pin the model on known vectors.
module tb_rv32_decode_exec_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] instr, pc, data1, data2;
    logic [4:0]  rs1, rs2, rd;
    logic        out_valid, wr_en, lw_en, sw_en, br_taken, illegal;
    logic [31:0] store_data, alu_out, br_target;

    rv32_decode_exec_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .instr(instr), .pc(pc),
        .data1(data1), .data2(data2), .rs1(rs1), .rs2(rs2), .out_valid(out_valid),
        .rd(rd), .wr_en(wr_en), .lw_en(lw_en), .sw_en(sw_en), .store_data(store_data),
        .alu_out(alu_out), .br_taken(br_taken), .br_target(br_target), .illegal(illegal)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit check_en = 1'b0;

    typedef struct packed {
        logic        valid, wr, lw, sw, br, ill;
        logic [4:0]  rd;
        logic [31:0] alu, tgt, sdata;
        logic        chk_data, chk_tgt, chk_sdata;
    } exp_t;

    exp_t exp_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Instruction-level reference: what each RV32I mnemonic must produce.
    function automatic exp_t model(input logic [31:0] i, input logic [31:0] p,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [6:0]  op  = i[6:0];
        logic [2:0]  f3  = i[14:12];
        logic [6:0]  f7  = i[31:25];
        logic [31:0] immi = {{20{i[31]}}, i[31:20]};
        logic [31:0] imms = {{20{i[31]}}, i[31:25], i[11:7]};
        logic [31:0] immb = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
        logic [31:0] rhs;
        logic signed [31:0] sa;
        bit ok;
        e = '0;
        e.valid = 1'b1;
        e.chk_data = 1'b1;
        ok = 1'b0;
        rhs = (op == 7'h33) ? b : immi;
        sa = a;
        if (op == 7'h33 || op == 7'h13) begin
            if (op == 7'h33)
                ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            else if (f3 == 3'd1)
                ok = (f7 == 7'h00);
            else if (f3 == 3'd5)
                ok = (f7 == 7'h00) || (f7 == 7'h20);
            else
                ok = 1'b1;
            case (f3)
                3'd0: e.alu = (op == 7'h33 && f7 == 7'h20) ? a - rhs : a + rhs;
                3'd1: e.alu = a << rhs[4:0];
                3'd2: e.alu = (sa < $signed(rhs)) ? 32'd1 : 32'd0;
                3'd3: e.alu = (a < rhs) ? 32'd1 : 32'd0;
                3'd4: e.alu = a ^ rhs;
                3'd5: e.alu = (f7 == 7'h20) ? 32'(sa >>> rhs[4:0]) : a >> rhs[4:0];
                3'd6: e.alu = a | rhs;
                default: e.alu = a & rhs;
            endcase
            e.wr = 1'b1;
            e.rd = i[11:7];
        end else if (op == 7'h03) begin
            ok = (f3 == 3'd2);
            e.alu = a + immi;
            e.wr = 1'b1;
            e.lw = 1'b1;
            e.rd = i[11:7];
        end else if (op == 7'h23) begin
            ok = (f3 == 3'd2);
            e.alu = a + imms;
            e.sw = 1'b1;
            e.sdata = b;
            e.chk_sdata = 1'b1;
        end else if (op == 7'h63) begin
            ok = (f3 != 3'd2 && f3 != 3'd3);
            e.tgt = p + immb;
            e.chk_tgt = 1'b1;
            case (f3)
                3'd0: e.br = (a == b);
                3'd1: e.br = (a != b);
                3'd4: e.br = ($signed(a) < $signed(b));
                3'd5: e.br = ($signed(a) >= $signed(b));
                3'd6: e.br = (a < b);
                default: e.br = (a >= b);
            endcase
        end
        if (!ok) begin
            e = '0;
            e.valid = 1'b1;
            e.ill = 1'b1;
            e.chk_data = 1'b1;
        end
        return e;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            exp_q <= '{chk_data: 1'b1, chk_tgt: 1'b1, chk_sdata: 1'b1, default: '0};
        end else if (!in_valid) begin
            exp_q <= '0;
        end else begin
            exp_q <= model(instr, pc, data1, data2);
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("cmp.out_valid", 32'(out_valid), 32'(exp_q.valid));
            chk("cmp.wr_en", 32'(wr_en), 32'(exp_q.wr));
            chk("cmp.lw_en", 32'(lw_en), 32'(exp_q.lw));
            chk("cmp.sw_en", 32'(sw_en), 32'(exp_q.sw));
            chk("cmp.br_taken", 32'(br_taken), 32'(exp_q.br));
            chk("cmp.illegal", 32'(illegal), 32'(exp_q.ill));
            if (exp_q.chk_data) begin
                chk("cmp.rd", 32'(rd), 32'(exp_q.rd));
                chk("cmp.alu_out", alu_out, exp_q.alu);
            end
            if (exp_q.chk_tgt) chk("cmp.br_target", br_target, exp_q.tgt);
            if (exp_q.chk_sdata) chk("cmp.store_data", store_data, exp_q.sdata);
        end
    end

    task automatic applyStimulus(input logic [31:0] i, input logic [31:0] p,
                                 input logic [31:0] d1, input logic [31:0] d2,
                                 input logic v = 1'b1);
        instr = i;
        pc = p;
        data1 = d1;
        data2 = d2;
        in_valid = v;
        #1;
        chk("rs1", 32'(rs1), 32'(i[19:15]));
        chk("rs2", 32'(rs2), 32'(i[24:20]));
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] e_alu, input logic [4:0] e_rd,
                               input logic e_valid, input logic e_wr, input logic e_lw,
                               input logic e_sw, input logic e_br, input logic e_ill);
        chk({tag, ".alu_out"}, alu_out, e_alu);
        chk({tag, ".rd"}, 32'(rd), 32'(e_rd));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(e_valid));
        chk({tag, ".wr_en"}, 32'(wr_en), 32'(e_wr));
        chk({tag, ".lw_en"}, 32'(lw_en), 32'(e_lw));
        chk({tag, ".sw_en"}, 32'(sw_en), 32'(e_sw));
        chk({tag, ".br_taken"}, 32'(br_taken), 32'(e_br));
        chk({tag, ".illegal"}, 32'(illegal), 32'(e_ill));
    endtask

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SUB  = 32'h402081B3;
    localparam logic [31:0] I_SRA  = 32'h4020D1B3;
    localparam logic [31:0] I_SRL  = 32'h0020D1B3;
    localparam logic [31:0] I_SLT  = 32'h0020A1B3;
    localparam logic [31:0] I_SLTU = 32'h0020B1B3;
    localparam logic [31:0] I_SRAI = 32'h41F0D193;
    localparam logic [31:0] I_LW   = 32'hFFC0A283;
    localparam logic [31:0] I_SW   = 32'h0020A423;
    localparam logic [31:0] I_BEQ  = 32'hFE208CE3;
    localparam logic [31:0] I_ADDI = 32'hFFF08213;
    localparam logic [31:0] I_AND  = 32'h0020F1B3;
    localparam logic [31:0] I_BLT  = 32'h0020C863;
    localparam logic [31:0] I_BLTU = 32'h0020E863;

    initial begin
        rst = 1'b1;
        in_valid = 1'b1;
        instr = I_ADD;
        pc = 32'h0;
        data1 = 32'd7;
        data2 = 32'd5;
        @(negedge clk);
        check_en = 1'b1;
        checkOutput("reset0", 32'h0, 5'd0, 0, 0, 0, 0, 0, 0);
        chk("reset0.br_target", br_target, 32'h0);
        chk("reset0.store_data", store_data, 32'h0);
        @(negedge clk);
        checkOutput("reset1", 32'h0, 5'd0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;

        applyStimulus(I_ADD, 32'h0, 32'd7, 32'd5);
        checkOutput("add", 32'd12, 5'd3, 1, 1, 0, 0, 0, 0);
        applyStimulus(I_SUB, 32'h4, 32'd7, 32'd5);
        checkOutput("sub", 32'd2, 5'd3, 1, 1, 0, 0, 0, 0);
        applyStimulus(I_SUB, 32'h8, 32'd0, 32'd1);
        checkOutput("sub_wrap", 32'hFFFFFFFF, 5'd3, 1, 1, 0, 0, 0, 0);
        applyStimulus(I_SRA, 32'hC, 32'h80000000, 32'd4);
        checkOutput("sra", 32'hF8000000, 5'd3, 1, 1, 0, 0, 0, 0);
        applyStimulus(I_SRL, 32'h10, 32'h80000000, 32'd4);
        checkOutput("srl", 32'h08000000, 5'd3, 1, 1, 0, 0, 0, 0);
        applyStimulus(I_SLT, 32'h14, 32'h80000000, 32'd4);
        checkOutput("slt", 32'd1, 5'd3, 1, 1, 0, 0, 0, 0);
        applyStimulus(I_SLTU, 32'h18, 32'h80000000, 32'd4);
        checkOutput("sltu", 32'd0, 5'd3, 1, 1, 0, 0, 0, 0);
        applyStimulus(I_SRAI, 32'h1C, 32'h80000000, 32'd4);
        checkOutput("srai31", 32'hFFFFFFFF, 5'd3, 1, 1, 0, 0, 0, 0);
        applyStimulus(I_LW, 32'h20, 32'h100, 32'h0);
        checkOutput("lw", 32'hFC, 5'd5, 1, 1, 1, 0, 0, 0);
        applyStimulus(I_SW, 32'h24, 32'h100, 32'hDEAD);
        checkOutput("sw", 32'h108, 5'd0, 1, 0, 0, 1, 0, 0);
        chk("sw.store_data", store_data, 32'hDEAD);
        applyStimulus(I_BEQ, 32'h40, 32'd3, 32'd3);
        checkOutput("beq_t", 32'h0, 5'd0, 1, 0, 0, 0, 1, 0);
        chk("beq_t.br_target", br_target, 32'h38);
        applyStimulus(I_BEQ, 32'h40, 32'd3, 32'd4);
        checkOutput("beq_nt", 32'h0, 5'd0, 1, 0, 0, 0, 0, 0);
        applyStimulus(32'h0000007F, 32'h44, 32'd3, 32'd4);
        checkOutput("illegal_op", 32'h0, 5'd0, 1, 0, 0, 0, 0, 1);
        applyStimulus(32'h0020C283, 32'h48, 32'h100, 32'd4);
        checkOutput("lw_bad_f3", 32'h0, 5'd0, 1, 0, 0, 0, 0, 1);
        applyStimulus(32'h0220C1B3, 32'h4C, 32'd1, 32'd2);
        checkOutput("bad_f7", 32'h0, 5'd0, 1, 0, 0, 0, 0, 1);

        // Back-to-back mixed stream, one result per cycle.
        applyStimulus(I_ADDI, 32'h50, 32'd10, 32'd0);
        checkOutput("s_addi", 32'd9, 5'd4, 1, 1, 0, 0, 0, 0);
        applyStimulus(I_AND, 32'h54, 32'hF0F0, 32'hFF00);
        checkOutput("s_and", 32'hF000, 5'd3, 1, 1, 0, 0, 0, 0);
        applyStimulus(I_BLT, 32'h58, 32'hFFFFFFFF, 32'd1);
        checkOutput("s_blt", 32'h0, 5'd0, 1, 0, 0, 0, 1, 0);
        chk("s_blt.br_target", br_target, 32'h68);
        applyStimulus(I_BLTU, 32'h5C, 32'hFFFFFFFF, 32'd1);
        checkOutput("s_bltu", 32'h0, 5'd0, 1, 0, 0, 0, 0, 0);

        applyStimulus(I_ADD, 32'h60, 32'd7, 32'd5, 1'b0);
        checkOutput("idle", alu_out, rd, 0, 0, 0, 0, 0, 0);

        applyStimulus(I_ADD, 32'h64, 32'd1, 32'd1);
        rst = 1'b1;
        applyStimulus(I_SUB, 32'h68, 32'd9, 32'd1);
        checkOutput("mid_reset", 32'h0, 5'd0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        applyStimulus(I_SUB, 32'h6C, 32'd9, 32'd1);
        checkOutput("post_reset", 32'd8, 5'd3, 1, 1, 0, 0, 0, 0);

        in_valid = 1'b0;
        @(negedge clk);
        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
